fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch sequencer for the rv32 instruction-fetch stage. Owns the PC and drives a variable-latency instruction memory through a req/ack handshake. Hands fetched instructions to decode through a valid/ready handshake. Applies branch redirects (PCsrc/branch_addr) and discards stale in-flight responses.

Parameters:
ADDR_W, 32, PC/memory address width
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
PCsrc  in  1  redirect request, sampled each cycle
branch_addr  in  ADDR_W  redirect target; bits [1:0] ignored and treated as 0
imem_req  out  1  memory request
imem_addr  out  ADDR_W  request address; held stable while imem_req=1 and no ack
imem_ack  in  1  transfer completes in any cycle with imem_req && imem_ack (ack may come in the same cycle as req)
imem_rdata  in  INSTR_W  valid only in an ack cycle
if_valid  out  1  instruction available to decode
if_instr  out  INSTR_W  fetched instruction
if_pc  out  ADDR_W  address of if_instr
if_ready  in  1  decode accepts; transfer when if_valid && if_ready

Behaviour:
- Reset: rst_n low at an edge sets state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0. Reset mid-transaction abandons it; a late ack while in IDLE is ignored.
- All outputs are registered. No combinational path from inputs to outputs.
- pc arithmetic: pc+4 modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0). Low 2 bits are always 0.
- PCsrc has the highest priority in every state except IDLE. In IDLE it still loads pc.
- IDLE: next state is FETCH. imem_req=1 and imem_addr=pc from the next cycle.
- FETCH (imem_req=1, imem_addr=inflight address):
  - ack && !PCsrc: if_instr<=imem_rdata, if_pc<=imem_addr, if_valid<=1, pc<=imem_addr+4, imem_req<=0, go to HOLD.
  - ack && PCsrc: discard data. pc<=branch_addr, imem_addr<=branch_addr, stay in FETCH with req high.
  - !ack && PCsrc: pc<=branch_addr, go to DRAIN. imem_addr stays unchanged (protocol rule).
  - !ack && !PCsrc: hold.
- DRAIN (imem_req=1, old address):
  - on ack: discard data, imem_addr<=pc, go to FETCH.
  - PCsrc in DRAIN: overwrites pc, stay in DRAIN.
  - PCsrc and ack in the same cycle: the new branch_addr is used for the next FETCH.
- HOLD (if_valid=1, imem_req=0; if_instr/if_pc stable while !if_ready):
  - if_ready && !PCsrc: if_valid<=0, imem_req<=1, imem_addr<=pc, go to FETCH.
  - PCsrc (with or without if_ready): if_valid<=0, pc and imem_addr<=branch_addr, go to FETCH. A same-cycle if_ready still counts as consumed.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.
- if_valid never rises in the cycle after a redirect is sampled.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on each if_valid && if_ready.
  - perf_stall_cnt increments on each cycle with imem_req && !imem_ack.
  - Both counters saturate at 0xFFFF_FFFF, clear on reset, and are registered.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset with RESET_PC=0x100, ack tied 1, if_ready=1. Required: imem_addr sequence 0x100, 0x104, 0x108, if_valid every other cycle, if_pc matching, if_instr = rdata.
2. Ack delayed 3 cycles at addr 0x10. Required: imem_addr stays 0x10 and req stays high throughout; one if_valid with if_pc=0x10; perf_stall_cnt=3 (macro on).
3. PCsrc=1 with branch_addr=0x203 while the 0x10 request is outstanding. Required: the 0x10 data is discarded; the next request is 0x200; no if_valid carries if_pc=0x10.
4. if_ready=0 for 5 cycles in HOLD. Required: if_instr/if_pc stable, imem_req=0. Then PCsrc=1 with branch_addr=0x40 and if_ready=1. Required: next imem_addr=0x40, if_valid=0.
5. pc=0xFFFF_FFFC, ack=1. Required: the next fetch address is 0x0000_0000.
6. rst_n=0 in DRAIN with ack arriving in the same cycle. Required: IDLE, all outputs 0, and the data is never presented on if_instr.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel plus the
// valid/ready channel toward decode. The master side is the fetch sequencer.
interface fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ack, imem_rdata, if_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rv32 fetch sequencer: owns the PC, drives imem req/ack, hands instructions to
// decode, applies redirects. Optional perf counters behind FETCH_PERF_CNT_EN.
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCsrc,
  input  logic [ADDR_W-1:0] branch_addr,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  fetch_if.master           bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic [ADDR_W-1:0]  br;

  assign br = {branch_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    case (state_q)
      IDLE: begin
        pc_d    = PCsrc ? br : pc_q;
        addr_d  = pc_d;
        req_d   = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          if (PCsrc) begin
            // Completed response belongs to the old path: drop it, reissue.
            pc_d   = br;
            addr_d = br;
          end else begin
            instr_d = bus.imem_rdata;
            ifpc_d  = addr_q;
            valid_d = 1'b1;
            pc_d    = addr_q + ADDR_W'(4);
            req_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (PCsrc) begin
          // Address must stay put until the memory acks the stale request.
          pc_d    = br;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (PCsrc) pc_d = br;
        if (bus.imem_ack) begin
          addr_d  = pc_d;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (PCsrc || bus.if_ready) begin
          valid_d = 1'b0;
          pc_d    = PCsrc ? br : pc_q;
          addr_d  = pc_d;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ifpc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_q, scnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (valid_q && bus.if_ready && fcnt_q != '1) fcnt_q <= fcnt_q + 32'd1;
      if (req_q && !bus.imem_ack && scnt_q != '1)  scnt_q <= scnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fcnt_q;
  assign perf_stall_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected decode transfers are queued by the
// stimulus and popped by an independent monitor; bus state is checked inline.
module tb_fetch_ctrl;
  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCsrc;
  logic [31:0] branch_addr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  fetch_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_ctrl #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .PCsrc(PCsrc),
    .branch_addr(branch_addr),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Memory model: data word is the address scrambled with a fixed key.
  assign bus.imem_rdata = bus.imem_addr ^ KEY;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer actual_pc=%h required=none", bus.if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("mon_pc", bus.if_pc, e);
        chk("mon_instr", bus.if_instr, e ^ KEY);
      end
    end
  end

  task automatic cyc(input logic s, input logic [31:0] b, input logic a, input logic r);
    PCsrc        = s;
    branch_addr  = b;
    bus.imem_ack = a;
    bus.if_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_valid", 32'(bus.if_valid), 0);
    chk("rst_instr", bus.if_instr, 0);
    chk("rst_pc", bus.if_pc, 0);

    // 1: zero-wait streaming from RESET_PC
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    rst_n = 1'b1;
    cyc(0, 0, 1, 1);
    chk("t1_addr0", bus.imem_addr, 32'h100);
    chk("t1_req0", 32'(bus.imem_req), 1);
    cyc(0, 0, 1, 1);
    chk("t1_valid0", 32'(bus.if_valid), 1);
    cyc(0, 0, 1, 1);
    chk("t1_addr1", bus.imem_addr, 32'h104);
    chk("t1_valid_gap", 32'(bus.if_valid), 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    chk("t1_addr2", bus.imem_addr, 32'h108);
    cyc(0, 0, 1, 1);
    chk("t1_valid2", 32'(bus.if_valid), 1);

    // 2: redirect to 0x10 then a 3-cycle ack delay
    exp_q.push_back(32'h10);
    cyc(1, 32'h10, 1, 1);
    chk("t2_addr", bus.imem_addr, 32'h10);
    chk("t2_valid_redir", 32'(bus.if_valid), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("t2_wait_addr", bus.imem_addr, 32'h10);
      chk("t2_wait_req", 32'(bus.imem_req), 1);
    end
    cyc(0, 0, 1, 0);
    chk("t2_valid", 32'(bus.if_valid), 1);
    chk("t2_pc", bus.if_pc, 32'h10);
`ifdef FETCH_PERF_CNT_EN
    chk("t2_stall_cnt", perf_stall_cnt, 3);
    chk("t2_fetch_cnt", perf_fetch_cnt, 3);
`endif

    // 3: redirect to 0x203 while the 0x10 refetch is outstanding
    exp_q.push_back(32'h200);
    cyc(1, 32'h10, 0, 1);
    chk("t3_addr10", bus.imem_addr, 32'h10);
    cyc(1, 32'h203, 0, 0);
    chk("t3_drain_addr", bus.imem_addr, 32'h10);
    chk("t3_drain_req", 32'(bus.imem_req), 1);
    chk("t3_drain_valid", 32'(bus.if_valid), 0);
    cyc(0, 0, 1, 0);
    chk("t3_new_addr", bus.imem_addr, 32'h200);
    chk("t3_no_valid", 32'(bus.if_valid), 0);
    cyc(0, 0, 1, 0);
    chk("t3_pc", bus.if_pc, 32'h200);

    // 4: decode stalls 5 cycles, then redirect with same-cycle ready
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0);
      chk("t4_valid", 32'(bus.if_valid), 1);
      chk("t4_pc", bus.if_pc, 32'h200);
      chk("t4_instr", bus.if_instr, 32'h200 ^ KEY);
      chk("t4_req", 32'(bus.imem_req), 0);
    end
    cyc(1, 32'h40, 1, 1);
    chk("t4_addr", bus.imem_addr, 32'h40);
    chk("t4_valid_off", 32'(bus.if_valid), 0);

    // 5: PC wrap at the top of the address space
    exp_q.push_back(32'hFFFF_FFFC);
    cyc(1, 32'hFFFF_FFFC, 1, 0);
    chk("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    chk("t5_valid_off", 32'(bus.if_valid), 0);
    cyc(0, 0, 1, 0);
    chk("t5_pc", bus.if_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("t5_wrap", bus.imem_addr, 32'h0);

    // 6: reset while draining, ack in the reset cycle
    cyc(1, 32'h80, 0, 0);
    chk("t6_drain_addr", bus.imem_addr, 32'h0);
    rst_n = 1'b0;
    cyc(0, 0, 1, 0);
    chk("t6_req", 32'(bus.imem_req), 0);
    chk("t6_addr", bus.imem_addr, 0);
    chk("t6_valid", 32'(bus.if_valid), 0);
    chk("t6_instr", bus.if_instr, 0);
    chk("t6_pc", bus.if_pc, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_fetch_cnt", perf_fetch_cnt, 0);
    chk("t6_stall_cnt", perf_stall_cnt, 0);
`endif
    cyc(0, 0, 1, 1);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1);
    chk("t6_restart_addr", bus.imem_addr, 32'h100);
    chk("t6_restart_valid", 32'(bus.if_valid), 0);
    cyc(0, 0, 0, 1);
    chk("t6_still_idle_valid", 32'(bus.if_valid), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
